// File: rtl/obc_da_engine.sv
// Bit-serial offset-binary-coding distributed-arithmetic engine: one DFT output
// component from 2*NPAIR samples, MSB-first Horner accumulation over DATA_W cycles.
module obc_da_engine #(
   parameter int DATA_W = 16,
   parameter int NPAIR  = 4,
   parameter int COEF_W = 32,
   parameter logic [NPAIR*2*COEF_W-1:0] LUT_BANK0 = '0,
   parameter logic [NPAIR*2*COEF_W-1:0] LUT_BANK1 = '0,
   parameter logic [COEF_W+DATA_W+$clog2(NPAIR)-1:0] OFFSET0 = '0,
   parameter logic [COEF_W+DATA_W+$clog2(NPAIR)-1:0] OFFSET1 = '0
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic                                     in_mode,
   input  logic [2*NPAIR*DATA_W-1:0]                in_data,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [COEF_W+DATA_W+$clog2(NPAIR)-1:0]   out_data,
   output logic                                     out_mode,
   output logic                                     busy
);
   localparam int ACC_W = COEF_W + DATA_W + $clog2(NPAIR);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

   state_t                      state_q, state_d;
   logic [2*NPAIR*DATA_W-1:0]   x_q, x_d;
   logic                        mode_q, mode_d;
   logic [ACC_W-1:0]            acc_q, acc_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [ACC_W-1:0]            out_data_q, out_data_d;
   logic                        out_mode_q, out_mode_d;

   logic                        sel_bit;
   logic signed [COEF_W-1:0]    coef;
   logic [ACC_W-1:0]            psum;
   logic [ACC_W-1:0]            acc_next;

   // Partial sum over all pairs for the current bit; LUT read straight from parameters.
   always_comb begin
      sel_bit  = 1'b0;
      coef     = '0;
      psum     = '0;
      for (int p = 0; p < NPAIR; p++) begin
         sel_bit = x_q[2*p*DATA_W + int'(cnt_q)] ^ x_q[(2*p+1)*DATA_W + int'(cnt_q)];
         coef    = mode_q ? LUT_BANK1[(2*p + int'(sel_bit))*COEF_W +: COEF_W]
                          : LUT_BANK0[(2*p + int'(sel_bit))*COEF_W +: COEF_W];
         psum    = psum + ACC_W'(coef);
      end
      // The sign bit carries weight -2^(DATA_W-1), so the first step negates.
      if (cnt_q == CNT_W'(DATA_W-1)) acc_next = -psum;
      else                           acc_next = (acc_q << 1) + psum;
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      mode_d     = mode_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;
      out_mode_d = out_mode_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = in_data;
               mode_d  = in_mode;
               acc_d   = '0;
               cnt_d   = CNT_W'(DATA_W-1);
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               out_data_d = acc_next + (mode_q ? OFFSET1 : OFFSET0);
               out_mode_d = mode_q;
               state_d    = OUT;
            end
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         x_q        <= '0;
         mode_q     <= 1'b0;
         acc_q      <= '0;
         cnt_q      <= '0;
         out_data_q <= '0;
         out_mode_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         mode_q     <= mode_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         out_data_q <= out_data_d;
         out_mode_q <= out_mode_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == OUT);
   assign out_data  = out_data_q;
   assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_obc_da_engine.sv
// Directed checks on a small 4-bit/1-pair engine plus randomized vectors on a
// default-size engine compared against a direct weighted-sum reference.
module tb_obc_da_engine;
   localparam logic [255:0] D_LB0 = {32'h8000_0001, 32'h7FFF_FFFF, 32'h1234_5678, 32'hF0E1_D2C3,
                                     32'h0000_0000, 32'hFFFF_FFFF, 32'h4C3B_2A19, 32'hA5A5_5A5A};
   localparam logic [255:0] D_LB1 = {32'h0F1E_2D3C, 32'hC001_CAFE, 32'h7654_3210, 32'h8888_7777,
                                     32'h0000_0001, 32'hDEAD_BEEF, 32'h3FFF_0000, 32'hFEDC_BA98};
   localparam logic [49:0]  D_OFF0 = 50'h2_DEAD_BEEF_0123;
   localparam logic [49:0]  D_OFF1 = 50'h1_0F0F_F0F0_5555;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // small engine: DATA_W=4, NPAIR=1, COEF_W=8 -> ACC_W=12
   logic        s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready, s_out_mode, s_busy;
   logic [7:0]  s_in_data;
   logic [11:0] s_out_data;

   obc_da_engine #(
      .DATA_W(4), .NPAIR(1), .COEF_W(8),
      .LUT_BANK0({8'd3, 8'd5}), .LUT_BANK1({8'd7, 8'hFE}),
      .OFFSET0(12'd0), .OFFSET1(12'd100)
   ) dut_s (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mode(s_in_mode), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .out_mode(s_out_mode), .busy(s_busy)
   );

   // default-size engine: ACC_W = 32+16+2 = 50
   logic         d_in_valid, d_in_ready, d_in_mode, d_out_valid, d_out_ready, d_out_mode, d_busy;
   logic [127:0] d_in_data;
   logic [49:0]  d_out_data;

   obc_da_engine #(
      .LUT_BANK0(D_LB0), .LUT_BANK1(D_LB1), .OFFSET0(D_OFF0), .OFFSET1(D_OFF1)
   ) dut_d (
      .clk(clk), .rst_n(rst_n),
      .in_valid(d_in_valid), .in_ready(d_in_ready), .in_mode(d_in_mode), .in_data(d_in_data),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
      .out_mode(d_out_mode), .busy(d_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Result = OFFSET + sum_b w_b * P_b, w_b = 2^b except MSB weight -2^15.
   function automatic logic [49:0] model(input logic [127:0] x, input logic m);
      logic [255:0] lut;
      logic [31:0]  c;
      longint       acc, p;
      int           s;
      lut = m ? D_LB1 : D_LB0;
      acc = longint'(m ? D_OFF1 : D_OFF0);
      for (int b = 0; b < 16; b++) begin
         p = 0;
         for (int pp = 0; pp < 4; pp++) begin
            s = int'(x[2*pp*16 + b] ^ x[(2*pp+1)*16 + b]);
            c = lut[(2*pp + s)*32 +: 32];
            p = p + longint'(signed'(c));
         end
         if (b == 15) acc = acc - p * 32768;
         else         acc = acc + p * (longint'(1) << b);
      end
      return acc[49:0];
   endfunction

   // Drives one vector into the small engine and checks exact latency and result.
   task automatic txn_s(input logic [3:0] x0, input logic [3:0] x1, input logic m,
                        input logic [11:0] exp, input string tag);
      @(negedge clk);
      chk({tag, "_in_ready"}, s_in_ready, 1);
      s_in_data = {x1, x0}; s_in_mode = m; s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0; s_in_data = 8'hA5; s_in_mode = ~m;
      chk({tag, "_busy"}, s_busy, 1);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         chk({tag, "_vld_timing"}, s_out_valid, (k == 4));
      end
      chk({tag, "_data"}, s_out_data, exp);
      chk({tag, "_mode"}, s_out_mode, m);
      if (s_out_ready) begin
         @(posedge clk); #1;
         chk({tag, "_drop"}, s_out_valid, 0);
      end
   endtask

   task automatic run_d(input logic [127:0] x, input logic m);
      logic [49:0] exp;
      int          k;
      exp = model(x, m);
      @(negedge clk);
      d_in_data = x; d_in_mode = m; d_in_valid = 1'b1;
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      for (int j = 0; j < 4; j++) d_in_data[j*32 +: 32] = $urandom;
      d_in_mode = ~m;
      k = 0;
      while (!d_out_valid && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      chk("d_latency", k, 16);
      chk("d_data", d_out_data, exp);
      chk("d_mode", d_out_mode, m);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [127:0] x;
      rst_n = 1'b0;
      s_in_valid = 0; s_in_mode = 0; s_in_data = '0; s_out_ready = 1;
      d_in_valid = 0; d_in_mode = 0; d_in_data = '0; d_out_ready = 1;
      #1;
      chk("rst_in_ready", s_in_ready, 1);
      chk("rst_out_valid", s_out_valid, 0);
      chk("rst_out_data", s_out_data, 0);
      chk("rst_out_mode", s_out_mode, 0);
      chk("rst_busy", s_busy, 0);
      chk("rst_d_in_ready", d_in_ready, 1);
      chk("rst_d_out_data", d_out_data, 0);
      @(negedge clk); rst_n = 1'b1;

      txn_s(4'h0, 4'h0, 1'b0, 12'hFFB, "zero");
      txn_s(4'hF, 4'h0, 1'b0, 12'hFFD, "allsel1");
      txn_s(4'h1, 4'h0, 1'b0, 12'hFF9, "lsb");
      txn_s(4'h5, 4'h3, 1'b1, 12'h09C, "bank1");

      // Backpressure with a second vector waiting on in_valid.
      s_out_ready = 1'b0;
      txn_s(4'h1, 4'h0, 1'b0, 12'hFF9, "bp_first");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         s_in_valid = 1'b1; s_in_data = {4'h3, 4'h5}; s_in_mode = 1'b1;
         @(posedge clk); #1;
         chk("bp_hold_data", s_out_data, 12'hFF9);
         chk("bp_hold_valid", s_out_valid, 1);
         chk("bp_in_ready", s_in_ready, 0);
      end
      @(negedge clk); s_out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_valid", s_out_valid, 0);
      chk("bp_idle_ready", s_in_ready, 1);
      @(posedge clk); #1;
      chk("bp_accept", s_busy, 1);
      s_in_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         chk("bp_second_vld", s_out_valid, (k == 4));
      end
      chk("bp_second_data", s_out_data, 12'h09C);
      chk("bp_second_mode", s_out_mode, 1);
      @(posedge clk); #1;

      // Asynchronous reset during the second RUN cycle.
      @(negedge clk);
      s_in_valid = 1'b1; s_in_data = {4'h3, 4'h5}; s_in_mode = 1'b1;
      @(posedge clk); #1; s_in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", s_in_ready, 1);
      chk("mid_rst_busy", s_busy, 0);
      chk("mid_rst_out_valid", s_out_valid, 0);
      chk("mid_rst_out_data", s_out_data, 0);
      chk("mid_rst_out_mode", s_out_mode, 0);
      @(negedge clk); rst_n = 1'b1;
      txn_s(4'h0, 4'h0, 1'b0, 12'hFFB, "post_rst");

      // Default-size engine: corners then random vectors and modes.
      for (int i = 0; i < 1000; i++) begin
         if (i < 2)      x = {8{16'h8000}};
         else if (i < 4) x = {8{16'h7FFF}};
         else for (int j = 0; j < 8; j++) x[j*16 +: 16] = 16'($urandom);
         run_d(x, 1'($urandom_range(0, 1)) ^ 1'(i & 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/obc_da_engine.md
Name: obc_da_engine

Overview:
- Parametrised bit-serial offset-binary-coding distributed-arithmetic engine for the DFT datapath.
- Generalises the fixed 4-pair, 2-entry imaginary-part coefficient ROMs into one block with:
  - a configurable number of sample pairs,
  - configurable sample and coefficient widths,
  - two selectable coefficient banks (real/imag),
  - on-chip shift-accumulation with valid/ready handshakes.
- One instance computes one DFT output component from 2*NPAIR input samples.

Parameters:
- DATA_W, 16: sample width, two's complement; also the number of RUN cycles.
- NPAIR, 4: number of sample pairs (2*NPAIR samples).
- COEF_W, 32: LUT entry width, signed fixed point (sign + 10 integer + 21 fraction bits by default).
- LUT_BANK0, 0: NPAIR*2*COEF_W packed. Entry (pair p, select s) sits at [(2p+s)*COEF_W +: COEF_W].
- LUT_BANK1, 0: second bank, same packing.
- OFFSET0, 0: ACC_W-bit signed constant added at the end for bank 0.
- OFFSET1, 0: ACC_W-bit signed constant added at the end for bank 1.
- ACC_W (localparam) = COEF_W + DATA_W + $clog2(NPAIR); equals COEF_W + DATA_W when NPAIR = 1.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: input vector valid.
- in_ready, output, 1: engine can accept a vector.
- in_mode, input, 1: bank select (0 = BANK0/OFFSET0, 1 = BANK1/OFFSET1).
- in_data, input, 2*NPAIR*DATA_W: sample i at [i*DATA_W +: DATA_W].
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts result.
- out_data, output, ACC_W: signed result.
- out_mode, output, 1: mode latched with this result.
- busy, output, 1: high in RUN or OUT.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_mode = 0, busy = 0. Accumulator, counter and sample registers are cleared.

FSM states: IDLE, RUN, OUT.
- in_ready = (state == IDLE). busy = (state != IDLE).
- IDLE:
  - On an edge with in_valid && in_ready: latch in_data and in_mode, acc = 0, cnt = DATA_W-1, go to RUN.
  - in_data and in_mode are ignored when not accepted.
- RUN: one bit per cycle, MSB first, bit index b = cnt.
  - For each pair p: sel_p = x[2p][b] XOR x[2p+1][b].
  - Partial sum P = sum over p of LUT[mode][p][sel_p], each entry sign-extended to ACC_W.
  - Horner update:
    - b = DATA_W-1: acc_next = -P.
    - otherwise: acc_next = (acc << 1) + P.
  - cnt decrements each cycle.
  - When b = 0: out_data = acc_next + OFFSET[mode], out_mode = mode, out_valid = 1, go to OUT.
- OUT:
  - out_data and out_mode are held stable while out_valid && !out_ready.
  - On an edge with out_ready: out_valid = 0, go to IDLE.
  - out_data keeps its last value after that.
- Arithmetic:
  - All ACC_W-bit two's complement; wraps modulo 2^ACC_W with no saturation.
  - Result = OFFSET + sum over b of w_b*P_b, where w_b = 2^b for b < DATA_W-1 and w_b = -2^(DATA_W-1) for the MSB.
- Timing:
  - out_valid rises exactly DATA_W rising edges after the accepting edge.
  - The next accept is possible one cycle after the output handshake.
  - Minimum period is DATA_W+2 cycles.
  - The LUT read is combinational from parameters; no LUT pipeline stage.
- in_valid held high during RUN/OUT is not accepted (in_ready = 0) and has no effect.
- out_ready high in IDLE/RUN has no effect.
- Reset asserted mid-RUN or mid-OUT:
  - The engine immediately returns to the reset values and the pending result is lost.
  - After release it behaves exactly as after power-up.
- Input changes during RUN have no effect (samples are latched).

Test Plan (override DATA_W = 4, NPAIR = 1, COEF_W = 8, so ACC_W = 12; LUT_BANK0: sel0 = 5, sel1 = 3; LUT_BANK1: sel0 = -2, sel1 = 7; OFFSET0 = 0, OFFSET1 = 12'd100):
- x0 = 0, x1 = 0, mode 0 -> out_data = -5 (12'hFFB), out_valid exactly 4 edges after accept, out_mode = 0.
- x0 = 4'hF, x1 = 0, mode 0 -> -3 (12'hFFD). Then x0 = 4'h1, x1 = 0 -> -7 (12'hFF9).
- x0 = 4'h5, x1 = 4'h3, mode 1:
  - select bits MSB to LSB = 0, 1, 1, 0.
  - result = 100 + (16 + 28 + 14 - 2) = 156 (12'h09C), out_mode = 1.
- Backpressure: hold out_ready = 0 for 10 cycles.
  - out_data stays stable; in_ready = 0; a second in_valid is not accepted.
  - After out_ready = 1: IDLE on the next edge; the second vector is accepted the following cycle.
- Reset mid-RUN (rst_n low at cycle 2 of RUN, asynchronously between edges):
  - Outputs go to reset values immediately.
  - A new vector x0 = 0, x1 = 0 then yields -5 with normal timing.
- Default parameters, random LUTs/offsets: 1000 random vectors and modes checked against a reference model of the result formula, including all-0x8000 and all-0x7FFF samples.
